uart_json_rx: RTL

//  Receive end of the robot UART link that json_to_uart_top transmits on GPIO[5].

---
 rtl/uart_json_rx.sv | 343 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_json_rx.sv
// uart_json_rx: oversampled 8N1 UART receiver followed by a small JSON
// scanner that extracts the decimal value of key "T" from {...} frames.
// Raw bytes are exposed alongside the decoded command for loopback checks.
module uart_json_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int MAX_FRAME  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic        frame_err,
    output logic [15:0] cmd_t,
    output logic        cmd_valid,
    output logic        parse_err,
    output logic        busy
);

    // Rounded divider from system clock to oversample tick.
    localparam int DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(MAX_FRAME + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BC_W-1:0]  FRAME_LIM = BC_W'(MAX_FRAME);

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_NINE   = 8'h39;

    // Key pattern "T": matched one character at a time.
    localparam logic [7:0] KEY [4] = '{8'h22, 8'h54, 8'h22, 8'h3A};

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT
    } r_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_SCAN,
        P_NUM
    } p_state_t;

    // ------------------------------------------------------------------
    // Synchroniser and edge detect
    // ------------------------------------------------------------------
    logic rx_s1_q, rx_s2_q, rx_prev_q;

    // Two-flop synchroniser plus one history flop for the falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    r_state_t r_state_q, r_state_d;
    logic     start_edge;

    assign start_edge = (r_state_q == R_IDLE) && rx_prev_q && !rx_s2_q;

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick;

    assign tick = (div_cnt_q == DIV_LAST);

    // Free-running divider, re-phased to the start edge so sampling is centred.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (tick || start_edge) begin
            div_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    logic [OS_W-1:0] os_cnt_q, os_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_byte_valid_q, rx_byte_valid_d;
    logic            frame_err_q, frame_err_d;

    // Receiver next-state: half a bit to the start centre, then full bits.
    always_comb begin
        r_state_d       = r_state_q;
        os_cnt_d        = os_cnt_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        rx_byte_d       = rx_byte_q;
        rx_byte_valid_d = 1'b0;
        frame_err_d     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (start_edge) begin
                    r_state_d = R_START;
                    os_cnt_d  = '0;
                end
            end
            R_START: begin
                if (tick) begin
                    if (os_cnt_q == OS_HALF) begin
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                        r_state_d = rx_s2_q ? R_IDLE : R_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            R_DATA: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        shift_d  = {rx_s2_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            r_state_d = R_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            R_STOP: begin
                if (tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        if (rx_s2_q) begin
                            rx_byte_d       = shift_q;
                            rx_byte_valid_d = 1'b1;
                            r_state_d       = R_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            r_state_d   = R_WAIT;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
            R_WAIT: begin
                if (rx_s2_q) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Receiver state and tick counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q       <= R_IDLE;
            div_cnt_q       <= '0;
            os_cnt_q        <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            rx_byte_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            r_state_q       <= r_state_d;
            div_cnt_q       <= div_cnt_d;
            os_cnt_q        <= os_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            rx_byte_q       <= rx_byte_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            frame_err_q     <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Parser FSM (consumes the registered byte strobe)
    // ------------------------------------------------------------------
    p_state_t        p_state_q, p_state_d;
    logic [1:0]      match_q, match_d;
    logic [BC_W-1:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
    logic            found_q, found_d;
    logic            ndig_q, ndig_d;
    logic [15:0]     acc_q, acc_d;
    logic [15:0]     latched_q, latched_d;
    logic [15:0]     cmd_t_q, cmd_t_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            parse_err_q, parse_err_d;
    logic [19:0]     acc_ext, acc_new;
    logic            is_digit;
    logic            p_done;
    logic [3:0]      key_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            assign key_hit[gi] = (rx_byte_q == KEY[gi]);
        end
    endgenerate

    assign is_digit     = (rx_byte_q >= CH_ZERO) && (rx_byte_q <= CH_NINE);
    assign acc_ext      = {4'b0, acc_q};
    assign acc_new      = (acc_ext << 3) + (acc_ext << 1) + {16'b0, rx_byte_q[3:0]};
    assign byte_cnt_inc = byte_cnt_q + 1'b1;

    // Parser next-state: brace framing, key matcher, decimal accumulator.
    always_comb begin
        p_state_d   = p_state_q;
        match_d     = match_q;
        byte_cnt_d  = byte_cnt_q;
        found_d     = found_q;
        ndig_d      = ndig_q;
        acc_d       = acc_q;
        latched_d   = latched_q;
        cmd_t_d     = cmd_t_q;
        cmd_valid_d = 1'b0;
        parse_err_d = 1'b0;
        p_done      = 1'b0;
        if (rx_byte_valid_q) begin
            if (rx_byte_q == CH_LBRACE) begin
                // A new '{' always (re)starts a frame, discarding any partial one.
                p_state_d  = P_SCAN;
                byte_cnt_d = BC_W'(1);
                found_d    = 1'b0;
                ndig_d     = 1'b0;
                acc_d      = '0;
                match_d    = '0;
            end else if (p_state_q != P_IDLE) begin
                byte_cnt_d = byte_cnt_inc;
                if (p_state_q == P_SCAN) begin
                    if (rx_byte_q == CH_RBRACE) begin
                        p_done    = 1'b1;
                        p_state_d = P_IDLE;
                        if (found_q) begin
                            cmd_t_d     = latched_q;
                            cmd_valid_d = 1'b1;
                        end else begin
                            parse_err_d = 1'b1;
                        end
                    end else if (key_hit[match_q]) begin
                        if (match_q == 2'd3) begin
                            p_state_d = P_NUM;
                            acc_d     = '0;
                            ndig_d    = 1'b0;
                            match_d   = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = (rx_byte_q == CH_QUOTE) ? 2'd1 : 2'd0;
                    end
                end else begin
                    if (is_digit) begin
                        if (acc_new > 20'd65535) begin
                            p_done      = 1'b1;
                            parse_err_d = 1'b1;
                            p_state_d   = P_IDLE;
                        end else begin
                            acc_d  = acc_new[15:0];
                            ndig_d = 1'b1;
                        end
                    end else if ((rx_byte_q == CH_COMMA) && ndig_q) begin
                        found_d   = 1'b1;
                        latched_d = acc_q;
                        match_d   = '0;
                        p_state_d = P_SCAN;
                    end else if ((rx_byte_q == CH_RBRACE) && ndig_q) begin
                        p_done      = 1'b1;
                        cmd_t_d     = acc_q;
                        cmd_valid_d = 1'b1;
                        p_state_d   = P_IDLE;
                    end else begin
                        p_done      = 1'b1;
                        parse_err_d = 1'b1;
                        p_state_d   = P_IDLE;
                    end
                end
                // Runaway frame: the limit is reached without a closing brace.
                if (!p_done && (byte_cnt_inc >= FRAME_LIM)) begin
                    parse_err_d = 1'b1;
                    p_state_d   = P_IDLE;
                end
            end
        end
    end

    // Parser state and registered result strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state_q   <= P_IDLE;
            match_q     <= '0;
            byte_cnt_q  <= '0;
            found_q     <= 1'b0;
            ndig_q      <= 1'b0;
            acc_q       <= '0;
            latched_q   <= '0;
            cmd_t_q     <= '0;
            cmd_valid_q <= 1'b0;
            parse_err_q <= 1'b0;
        end else begin
            p_state_q   <= p_state_d;
            match_q     <= match_d;
            byte_cnt_q  <= byte_cnt_d;
            found_q     <= found_d;
            ndig_q      <= ndig_d;
            acc_q       <= acc_d;
            latched_q   <= latched_d;
            cmd_t_q     <= cmd_t_d;
            cmd_valid_q <= cmd_valid_d;
            parse_err_q <= parse_err_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign frame_err     = frame_err_q;
    assign cmd_t         = cmd_t_q;
    assign cmd_valid     = cmd_valid_q;
    assign parse_err     = parse_err_q;
    assign busy          = (r_state_q != R_IDLE);

endmodule
